// File: rtl/axi_stream_fifo_if.sv
// AXI4-Stream beat bundle shared by the FIFO's input and output sides.
// A beat transfers on a rising edge where tvalid && tready; once tvalid is high the master holds it and
// every payload field stable until that transfer, and tready may change freely without waiting on tvalid.
interface axi_stream_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [USER_WIDTH-1:0]   tuser;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [ID_WIDTH-1:0]     tid;

  modport master (
    output tdata, tvalid, tlast, tstrb, tkeep, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tstrb, tkeep, tuser, tdest, tid,
    output tready
  );
endinterface

// File: rtl/axi_stream_fifo.sv
// Single-clock AXI4-Stream FIFO carrying every sideband field; registered s_tready, head beat read from storage.
// Optional store-and-forward release is enabled by defining AXIS_FIFO_PACKET_MODE_EN.
module axi_stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1,
  parameter int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi_stream_fifo_if.slave      s,
  axi_stream_fifo_if.master     m,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  full,
`ifdef AXIS_FIFO_PACKET_MODE_EN
  output logic [ADDR_WIDTH:0]   pkt_count,
`endif
  output logic                  empty
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int BEAT_WIDTH = DATA_WIDTH + 1 + 2 * STRB_WIDTH + USER_WIDTH + DEST_WIDTH + ID_WIDTH;
  localparam int LAST_BIT   = DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [BEAT_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   fill_q;
  logic [ADDR_WIDTH:0]   fill_next;
  logic                  s_ready_q;
  logic                  m_valid;
  logic                  push;
  logic                  pop;
  logic                  full_int;
  logic [BEAT_WIDTH-1:0] wr_beat;
  logic [BEAT_WIDTH-1:0] rd_beat;

  assign push = s.tvalid && s_ready_q;
  assign pop  = m_valid && m.tready;

  assign wr_beat = {s.tid, s.tdest, s.tuser, s.tkeep, s.tstrb, s.tlast, s.tdata};

  always_comb begin
    fill_next = fill_q;
    case ({push, pop})
      2'b10:   fill_next = fill_q + 1'b1;
      2'b01:   fill_next = fill_q - 1'b1;
      default: fill_next = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fill_q    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fill_q    <= fill_next;
      s_ready_q <= (fill_next < FULL_LEVEL);
    end
  end

  // Storage is deliberately left out of reset; stale entries are never visible because m_valid gates them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_beat;
  end

  assign full_int = (fill_q == FULL_LEVEL);

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [ADDR_WIDTH:0] pkt_q;
  logic                pkt_in;
  logic                pkt_out;

  assign pkt_in  = push && s.tlast;
  assign pkt_out = pop && rd_beat[LAST_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q <= '0;
    end else begin
      case ({pkt_in, pkt_out})
        2'b10:   pkt_q <= pkt_q + 1'b1;
        2'b01:   pkt_q <= pkt_q - 1'b1;
        default: pkt_q <= pkt_q;
      endcase
    end
  end

  // Releasing on full lets a packet longer than the FIFO drain instead of stalling forever.
  assign m_valid   = (fill_q != '0) && ((pkt_q != '0) || full_int);
  assign pkt_count = pkt_q;
`else
  assign m_valid = (fill_q != '0);
`endif

  assign rd_beat = m_valid ? mem[rd_ptr] : '0;

  assign s.tready = s_ready_q;
  assign m.tvalid = m_valid;
  assign {m.tid, m.tdest, m.tuser, m.tkeep, m.tstrb, m.tlast, m.tdata} = rd_beat;

  assign fill_count = fill_q;
  assign full       = full_int;
  assign empty      = (fill_q == '0);

endmodule
